// File: rtl/hit_pkg.sv
// Shared FSM state encoding and counter sizing for the button input conditioner.
package hit_pkg;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DB_PRESS   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] DB_RELEASE = 2'd3;

    // Bits needed to hold 0..max_val-1, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val <= 2) begin
            return 1;
        end
        return $clog2(max_val);
    endfunction

endpackage

// File: rtl/hit_debounce_if.sv
// Button-side bundle: raw line in, conditioned level/pulse/clean line out.
interface hit_debounce_if;
    logic hit_raw;
    logic hit_clean;
    logic hit_level;
    logic hit_pulse;

    modport master (output hit_raw, input hit_clean, input hit_level, input hit_pulse);
    modport slave  (input hit_raw, output hit_clean, output hit_level, output hit_pulse);
endinterface

// File: rtl/hit_sync.sv
// Two-flop synchroniser for an asynchronous level, reset to a chosen idle value.
// Latency: 2 cycles from d to q.
// Backpressure: none; free-running sampler.
module hit_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/hit_debounce.sv
// Debounces a push-button into a clean level plus one pulse per press and per auto-repeat.
// Latency: DB_CYCLES+2 cycles from first stable sample to level/pulse change (press and release).
// Backpressure: none; pulses are fire-and-forget to the downstream counter.
module hit_debounce
    import hit_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic          clk,
    input  logic          reset,
    hit_debounce_if.slave hit
);
    localparam int DB_W  = cnt_width(DB_CYCLES);
    localparam int RPT_W = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic raw_s;
    logic pressed;

    logic [1:0]       state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;

    hit_sync #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (hit.hit_raw),
        .q     (raw_s)
    );

    assign pressed = raw_s ^ ACTIVE_LOW;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        pulse_d     = 1'b0;
        level_d     = level_q;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = '0;
                end
            end
            DB_PRESS: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    rpt_cnt_d   = '0;
                    rpt_phase_d = 1'b0;
                    pulse_d     = 1'b1;
                    level_d     = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = '0;
                end else if (REPEAT_DELAY != 0) begin
                    // First target is the initial delay, then the repeat period.
                    if (rpt_cnt_q == (rpt_phase_q ? RPT_NEXT : RPT_FIRST)) begin
                        pulse_d     = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            DB_RELEASE: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            pulse_q     <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            pulse_q     <= pulse_d;
            level_q     <= level_d;
        end
    end

    assign hit.hit_level = level_q;
    assign hit.hit_pulse = pulse_q;
    assign hit.hit_clean = level_q ^ ACTIVE_LOW;
endmodule

// File: tb/tb_hit_debounce.sv
// Vector-driven bench: per-edge raw/reset patterns, pulse scoreboard, level/clean checks.
module tb_hit_debounce;
    logic clk = 1'b0;
    logic reset;

    hit_debounce_if hif();

    hit_debounce #(
        .ACTIVE_LOW    (1'b1),
        .DB_CYCLES     (4),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hit   (hif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic [63:0] raw;
        logic [63:0] rst;
        logic [63:0] pulse;
        logic [63:0] level;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_bit(input string what, input int e, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0b want=%0b", what, e, got, want);
        end
    endtask

    task automatic prime();
        @(negedge clk);
        reset       = 1'b1;
        hif.hit_raw = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Edge e samples raw[e]/rst[e]; outputs are read 1 time unit after edge e.
    task automatic run_vec(input vec_t v);
        prime();
        exp_q.delete();
        for (int e = 0; e < v.n; e++) if (v.pulse[e]) exp_q.push_back(e);
        for (int e = 0; e < v.n; e++) begin
            @(negedge clk);
            hif.hit_raw = v.raw[e];
            reset       = v.rst[e];
            @(posedge clk);
            #1;
            if (hif.hit_pulse === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_pulse edge=%0d got=1 want=0", v.name, e);
                end else begin
                    int want_e = exp_q.pop_front();
                    if (want_e != e) begin
                        failures++;
                        $display("FAIL %s pulse_edge got=%0d want=%0d", v.name, e, want_e);
                    end
                end
            end
            check_bit({v.name, " level"}, e, hif.hit_level, v.level[e]);
            check_bit({v.name, " clean"}, e, hif.hit_clean, ~v.level[e]);
        end
        while (exp_q.size() != 0) begin
            int miss_e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s missing_pulse got=none want=edge%0d", v.name, miss_e);
        end
        reset = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        reset       = 1'b1;
        hif.hit_raw = 1'b1;

        vecs[0] = '{"idle",        23, '1,                            span(0, 2),   '0,
                    '0};
        vecs[1] = '{"press12",     24, ~span(0, 11),                  '0,           span(6, 6),
                    span(6, 17)};
        vecs[2] = '{"bounce",      16, ~(span(0, 1) | span(3, 4)),    '0,           '0,
                    '0};
        vecs[3] = '{"hold30",      44, ~span(0, 29),                  '0,
                    span(6, 6) | span(14, 14) | span(18, 18) | span(22, 22) | span(26, 26) | span(30, 30),
                    span(6, 35)};
        vecs[4] = '{"glitch",      24, ~(span(0, 7) | span(10, 11)),  '0,           span(6, 6),
                    span(6, 17)};
        vecs[5] = '{"rst_dbpress", 20, '0,                            span(4, 4),   span(11, 11) | span(19, 19),
                    span(11, 19)};
        vecs[6] = '{"rst_held",    22, '0,                            span(14, 14), span(6, 6) | span(21, 21),
                    span(6, 13) | span(21, 21)};

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while debouncing a release: level must drop on the reset edge, no pulse.
        begin
            int pulses = 0;
            prime();
            for (int e = 0; e < 14; e++) begin
                @(negedge clk);
                hif.hit_raw = (e >= 10);
                reset       = (e == 13);
                @(posedge clk);
                #1;
                if (hif.hit_pulse === 1'b1) pulses++;
                if (e == 12) check_bit("rel_reset level_in_db_release", e, hif.hit_level, 1'b1);
            end
            check_bit("rel_reset level_after_reset", 13, hif.hit_level, 1'b0);
            check_bit("rel_reset clean_after_reset", 13, hif.hit_clean, 1'b1);
            check_bit("rel_reset pulse_after_reset", 13, hif.hit_pulse, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            repeat (8) begin
                @(posedge clk);
                #1;
                if (hif.hit_pulse === 1'b1) pulses++;
            end
            check_bit("rel_reset level_quiet", 21, hif.hit_level, 1'b0);
            checks++;
            if (pulses != 1) begin
                failures++;
                $display("FAIL rel_reset pulse_count got=%0d want=1", pulses);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
